// File: rtl/pixel_loader.sv
`default_nettype none
// ============================================================================
// Module      : pixel_loader
// Description : Captures a serial byte frame of binarized pixels followed by
//               layer-one weight bytes into parallel image/weight registers.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_loader #(
    parameter int N_PIX    = 784,
    parameter int N_WBYTES = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             state,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic [27:0][27:0]      pixels,
    output logic [2:0][2:0][7:0]   weights,
    output logic [6:0]             byte_count,
    output logic                   load_done,
    output logic                   overrun
);

    localparam logic [2:0] c_ST_IDLE    = 3'b000;
    localparam logic [2:0] c_ST_LOAD    = 3'b001;

    localparam logic [6:0] c_PIX_BYTES  = 7'(N_PIX / 8);
    localparam logic [6:0] c_FRAME      = 7'((N_PIX / 8) + N_WBYTES);
    localparam logic [6:0] c_LAST_BYTE  = 7'((N_PIX / 8) + N_WBYTES - 1);

    logic [783:0] r_pix;
    logic [71:0]  r_wts;
    logic [6:0]   r_count;
    logic         r_done;
    logic         r_overrun;

    logic         w_in_load;
    logic         w_accept;
    logic         w_pix_phase;
    logic         w_wt_phase;
    logic [9:0]   w_pix_base;
    logic [6:0]   w_wt_sel;
    logic [6:0]   w_wt_base;

    assign w_in_load   = (state == c_ST_LOAD);
    assign in_ready    = w_in_load && !r_done;
    assign w_accept    = in_valid && in_ready;

    // Destination is chosen purely from the running count.
    assign w_pix_phase = (r_count < c_PIX_BYTES);
    assign w_wt_phase  = (r_count >= c_PIX_BYTES) && (r_count < c_FRAME);
    assign w_pix_base  = {r_count, 3'b000};
    assign w_wt_sel    = r_count - c_PIX_BYTES;
    assign w_wt_base   = {w_wt_sel[3:0], 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pix     <= '0;
            r_wts     <= '0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (state)
                c_ST_IDLE: begin
                    r_count <= '0;
                    r_done  <= 1'b0;
                end
                c_ST_LOAD: begin
                    if (in_valid && r_done) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_accept) begin
                        if (w_pix_phase) begin
                            r_pix[w_pix_base +: 8] <= in_data;
                        end else if (w_wt_phase) begin
                            r_wts[w_wt_base +: 8] <= in_data;
                        end
                        if (r_count < c_FRAME) begin
                            r_count <= r_count + 7'd1;
                        end
                        if (r_count == c_LAST_BYTE) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    // Layer states and unused codes freeze the frame.
                end
            endcase
        end
    end

    assign pixels     = r_pix;
    assign weights    = r_wts;
    assign byte_count = r_count;
    assign load_done  = r_done;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pixel_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_loader
// Description : Directed self-checking bench for pixel_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_loader;

    logic                 clk;
    logic                 rst_n;
    logic [2:0]           state;
    logic                 in_valid;
    logic [7:0]           in_data;
    logic                 in_ready;
    logic [27:0][27:0]    pixels;
    logic [2:0][2:0][7:0] weights;
    logic [6:0]           byte_count;
    logic                 load_done;
    logic                 overrun;

    int checks   = 0;
    int failures = 0;

    logic [783:0] exp_pix;
    logic [71:0]  exp_wt;

    pixel_loader #(.N_PIX(784), .N_WBYTES(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .pixels     (pixels),
        .weights    (weights),
        .byte_count (byte_count),
        .load_done  (load_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: apply inputs, pass the rising edge, settle 1 time unit.
    task automatic drive(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        state = 3'b000;
        drive(1'b0, 8'h00);
        rst_n = 1'b1;
        exp_pix = '0;
        exp_wt  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        state = 3'b001;
        drive(1'b1, 8'hFF);
        drive(1'b1, 8'hFF);
        checks++; if (byte_count !== 7'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", byte_count); end
        checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", load_done); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (pixels !== 784'd0) begin failures++; $display("FAIL reset_pixels got=%h exp=0", pixels); end
        checks++; if (weights !== 72'd0) begin failures++; $display("FAIL reset_weights got=%h exp=0", weights); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_full_ff();
        do_reset();
        state = 3'b001;
        for (int i = 0; i < 107; i++) begin
            drive(1'b1, 8'hFF);
            if (i == 105) begin
                checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL full_done_early got=%b exp=0", load_done); end
            end
        end
        in_valid = 1'b0;
        checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL full_done got=%b exp=1", load_done); end
        checks++; if (byte_count !== 7'd107) begin failures++; $display("FAIL full_count got=%0d exp=107", byte_count); end
        checks++; if (pixels !== {784{1'b1}}) begin failures++; $display("FAIL full_pixels got=%h exp=all ones", pixels); end
        checks++; if (weights !== {9{8'hFF}}) begin failures++; $display("FAIL full_weights got=%h exp=all ff", weights); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        drive(1'b0, 8'h00);
        checks++; if (byte_count !== 7'd107) begin failures++; $display("FAIL full_count_hold got=%0d exp=107", byte_count); end
    endtask

    task automatic test_single_bits();
        logic [7:0] d;
        do_reset();
        state = 3'b001;
        for (int i = 0; i < 107; i++) begin
            d = (i == 0) ? 8'h01 : ((i == 98) ? 8'hA5 : 8'h00);
            drive(1'b1, d);
        end
        in_valid = 1'b0;
        exp_pix = '0; exp_pix[0] = 1'b1;
        exp_wt  = '0; exp_wt[7:0] = 8'hA5;
        checks++; if (pixels[0][0] !== 1'b1) begin failures++; $display("FAIL single_p00 got=%b exp=1", pixels[0][0]); end
        checks++; if (pixels !== exp_pix) begin failures++; $display("FAIL single_pixels got=%h exp=%h", pixels, exp_pix); end
        checks++; if (weights[0][0] !== 8'hA5) begin failures++; $display("FAIL single_w00 got=%h exp=a5", weights[0][0]); end
        checks++; if (weights !== exp_wt) begin failures++; $display("FAIL single_weights got=%h exp=%h", weights, exp_wt); end
    endtask

    task automatic test_row_map();
        logic [7:0] d;
        do_reset();
        state = 3'b001;
        for (int i = 0; i < 7; i++) begin
            d = (i == 3) ? 8'h10 : ((i == 6) ? 8'h80 : 8'h00);
            drive(1'b1, d);
        end
        in_valid = 1'b0;
        exp_pix = '0; exp_pix[28] = 1'b1; exp_pix[55] = 1'b1;
        checks++; if (pixels[1][0] !== 1'b1) begin failures++; $display("FAIL row_p10 got=%b exp=1", pixels[1][0]); end
        checks++; if (pixels[1][27] !== 1'b1) begin failures++; $display("FAIL row_p127 got=%b exp=1", pixels[1][27]); end
        checks++; if (pixels[0] !== 28'd0) begin failures++; $display("FAIL row_row0 got=%h exp=0", pixels[0]); end
        checks++; if (pixels !== exp_pix) begin failures++; $display("FAIL row_pixels got=%h exp=%h", pixels, exp_pix); end
        checks++; if (byte_count !== 7'd7) begin failures++; $display("FAIL row_count got=%0d exp=7", byte_count); end
    endtask

    task automatic send_pattern(input int idx);
        logic [7:0] d;
        d = 8'(idx) ^ 8'h5A;
        if (idx < 98) exp_pix[idx*8 +: 8] = d;
        else          exp_wt[(idx-98)*8 +: 8] = d;
        drive(1'b1, d);
    endtask

    task automatic test_freeze();
        do_reset();
        state = 3'b001;
        for (int i = 0; i < 50; i++) send_pattern(i);
        state = 3'b010;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 8'hEE);
            checks++; if (byte_count !== 7'd50) begin failures++; $display("FAIL freeze_count cyc=%0d got=%0d exp=50", c, byte_count); end
        end
        checks++; if (pixels !== exp_pix) begin failures++; $display("FAIL freeze_pixels got=%h exp=%h", pixels, exp_pix); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL freeze_overrun got=%b exp=0", overrun); end
        state = 3'b001;
        for (int i = 50; i < 107; i++) begin
            send_pattern(i);
            if (i == 105) begin
                checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL freeze_done_early got=%b exp=0", load_done); end
            end
        end
        in_valid = 1'b0;
        checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL freeze_done got=%b exp=1", load_done); end
        checks++; if (pixels !== exp_pix) begin failures++; $display("FAIL freeze_final_pix got=%h exp=%h", pixels, exp_pix); end
        checks++; if (weights !== exp_wt) begin failures++; $display("FAIL freeze_final_wt got=%h exp=%h", weights, exp_wt); end
    endtask

    // Relies on the completed frame left by test_freeze.
    task automatic test_overrun();
        state = 3'b001;
        drive(1'b1, 8'h00);
        in_valid = 1'b0;
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        checks++; if (pixels !== exp_pix) begin failures++; $display("FAIL ovr_pixels got=%h exp=%h", pixels, exp_pix); end
        checks++; if (byte_count !== 7'd107) begin failures++; $display("FAIL ovr_count got=%0d exp=107", byte_count); end
        state = 3'b000;
        drive(1'b0, 8'h00);
        checks++; if (byte_count !== 7'd0) begin failures++; $display("FAIL idle_count got=%0d exp=0", byte_count); end
        checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL idle_done got=%b exp=0", load_done); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL idle_overrun got=%b exp=1", overrun); end
        checks++; if (pixels !== exp_pix) begin failures++; $display("FAIL idle_pixels got=%h exp=%h", pixels, exp_pix); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL idle_in_ready got=%b exp=0", in_ready); end
        state = 3'b001;
        drive(1'b1, 8'hC3);
        in_valid = 1'b0;
        exp_pix[7:0] = 8'hC3;
        checks++; if (byte_count !== 7'd1) begin failures++; $display("FAIL restart_count got=%0d exp=1", byte_count); end
        checks++; if (pixels !== exp_pix) begin failures++; $display("FAIL restart_pixels got=%h exp=%h", pixels, exp_pix); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        state = 3'b001;
        for (int i = 0; i < 60; i++) drive(1'b1, 8'hFF);
        rst_n = 1'b0;
        drive(1'b1, 8'hFF);
        checks++; if (byte_count !== 7'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", byte_count); end
        checks++; if (pixels !== 784'd0) begin failures++; $display("FAIL midrst_pixels got=%h exp=0", pixels); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL midrst_overrun got=%b exp=0", overrun); end
        rst_n = 1'b1;
        drive(1'b1, 8'h03);
        in_valid = 1'b0;
        exp_pix = '0; exp_pix[1:0] = 2'b11;
        checks++; if (pixels[0][0] !== 1'b1 || pixels[0][1] !== 1'b1) begin failures++; $display("FAIL midrst_p00_p01 got=%b%b exp=11", pixels[0][1], pixels[0][0]); end
        checks++; if (pixels !== exp_pix) begin failures++; $display("FAIL midrst_pixels_after got=%h exp=%h", pixels, exp_pix); end
        checks++; if (byte_count !== 7'd1) begin failures++; $display("FAIL midrst_count_after got=%0d exp=1", byte_count); end
    endtask

    initial begin
        rst_n    = 1'b0;
        state    = 3'b000;
        in_valid = 1'b0;
        in_data  = 8'h00;
        exp_pix  = '0;
        exp_wt   = '0;
        test_reset();
        test_full_ff();
        test_single_bits();
        test_row_map();
        test_freeze();
        test_overrun();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_loader.md
PIXEL_LOADER -- requirements
Module: pixel_loader

Interface
REQ-001 SHALL have parameter N_PIX, default 784, meaning image pixels (28x28, 1 bit each).
REQ-002 SHALL have parameter N_WBYTES, default 9, meaning weight bytes (3x3 taps x 8 filters).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port state  input  3  top-level state: IDLE=000, LOAD=001, LAYER_1=010, LAYER_2=011, LAYER_3=100.
REQ-006 SHALL have port in_valid  input  1  in_data holds a byte this cycle.
REQ-007 SHALL have port in_data  input  8  serial byte stream.
REQ-008 SHALL have port in_ready  output  1  block accepts a byte this cycle.
REQ-009 SHALL have port pixels  output  28x28x1 packed [27:0][27:0]  binarized image for layer_one.
REQ-010 SHALL have port weights  output  3x3x8 packed [2:0][2:0][7:0]  layer-one weights; bit k = filter k.
REQ-011 SHALL have port byte_count  output  7  bytes accepted in the current frame, 0..107.
REQ-012 SHALL have port load_done  output  1  full frame (107 bytes) captured.
REQ-013 SHALL have port overrun  output  1  sticky: in_valid seen while state=LOAD and load_done=1.

Function
REQ-014 SHALL define a frame as 98 pixel bytes (784/8) followed by 9 weight bytes, 107 bytes total.
REQ-015 SHALL drive in_ready = (state==LOAD) && !load_done, combinationally.
REQ-016 SHALL accept a byte on a rising edge when in_valid && in_ready; no other byte is accepted.
REQ-017 SHALL map pixel byte k (0..97) bit b to pixel index p=8k+b; pixels[p/28][p%28] = in_data[b] (LSB first, row-major).
REQ-018 SHALL map weight byte j (0..8) to weights[j/3][j%3] = in_data[7:0].
REQ-019 SHALL update the addressed pixel/weight bits and increment byte_count on the same edge that accepts the byte; other bits are unchanged.
REQ-020 SHALL set load_done=1 on the edge that accepts byte 106 (byte_count becomes 107).
REQ-021 SHALL hold byte_count, load_done, pixels and weights stable while state is LAYER_1, LAYER_2 or LAYER_3.
REQ-022 SHALL, when state=IDLE, clear byte_count and load_done on each edge; pixels and weights retain values.
REQ-023 SHALL, when state leaves LOAD before load_done (to any non-IDLE state), freeze byte_count; re-entering LOAD resumes at the frozen count.
REQ-024 SHALL ignore bytes when state!=LOAD regardless of in_valid.
REQ-025 SHALL ignore bytes when load_done=1 and set overrun=1 if in_valid=1 in state LOAD; overrun clears only on reset.
REQ-026 SHALL use a byte_count compare (<98 pixel phase, 98..106 weight phase) to select the destination; no separate phase register required.
REQ-027 SHALL never write past pixel index 783 or weight byte 8; byte_count saturates at 107.
REQ-028 SHALL place reset behavior above all other updates when rst_n=0 coincides with a valid byte.

Reset
REQ-029 SHALL, on a rising edge with rst_n=0, set byte_count=0, load_done=0, overrun=0, pixels=all 0, weights=all 0.
REQ-030 SHALL give reset priority mid-frame; after release the next accepted byte is pixel byte 0.
REQ-031 SHALL drive in_ready from state alone during reset (combinational), but accept no byte while rst_n=0.

Verification
REQ-032 Reset, state=LOAD, send 107 bytes 0xFF with in_valid held high -> load_done=1 exactly 107 cycles after first valid; all pixels=1; all weights=0xFF; in_ready=0 afterwards.
REQ-033 Send byte0=0x01, bytes1..97=0x00, byte98=0xA5, rest 0x00 -> pixels[0][0]=1 only; weights[0][0]=0xA5; others 0.
REQ-034 Byte 3 = 0x10 (p=28) and byte 6 = 0x80 (p=55) -> pixels[1][0]=1, pixels[1][27]=1; row 0 untouched.
REQ-035 After 50 bytes switch state to LAYER_1 for 10 cycles with in_valid=1, return to LOAD -> byte_count stays 50 during LAYER_1, load resumes at byte 50, load_done after 57 more bytes.
REQ-036 After load_done, state=LOAD, in_valid=1 one cycle -> overrun=1, pixels unchanged; then state=IDLE one cycle -> byte_count=0, load_done=0, overrun still 1.
REQ-037 Assert rst_n=0 at byte 60 with in_valid=1 -> byte_count=0, pixels all 0; next byte 0x03 writes pixels[0][0]=pixels[0][1]=1.
